// File: rtl/pumpen_pkg.sv
// Shared pump-level definitions: plausibility FSM states, fail-safe vector and
// the legal level codes, also used by the downstream pump control FSM.
package pumpen_pkg;

  typedef enum logic {
    PS_OK    = 1'b0,
    PS_FAULT = 1'b1
  } plaus_state_e;

  localparam logic [2:0] FAILSAFE_VEC = 3'b111;

  // Wet sensors must fill from the bottom up; anything else is a broken switch.
  localparam logic [2:0] LVL_EMPTY = 3'b000;
  localparam logic [2:0] LVL_LOW   = 3'b001;
  localparam logic [2:0] LVL_MID   = 3'b011;
  localparam logic [2:0] LVL_FULL  = 3'b111;

  function automatic logic is_plausible(input logic [2:0] v);
    return (v == LVL_EMPTY) || (v == LVL_LOW) || (v == LVL_MID) || (v == LVL_FULL);
  endfunction

endpackage

// File: rtl/entprell_kanal.sv
// One sensor channel: two-flop synchronizer followed by a debounce counter.
// acc_d_o exposes the next accepted value so the top can register outputs without extra latency.
module entprell_kanal #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic acc_o,
  output logic acc_d_o
);

  logic          sync1_q, sync2_q;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Counter only runs while the sample disagrees; the edge that would hit
  // DEBOUNCE_CYCLES flips the accepted value and restarts from zero instead.
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        acc_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o   = acc_q;
  assign acc_d_o = acc_d;

endmodule

// File: rtl/pegel_filter.sv
// Level sensor filter: debounces three level switches and, with PLAUSI_CHECK_EN
// defined, adds a plausibility FSM that forces the fail-safe vector on a fault.
module pegel_filter
  import pumpen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sensor_raw,
  input  logic       fault_clr,
  output logic [2:0] x,
  output logic       fault
);

  logic [2:0] acc_q, acc_d;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    entprell_kanal #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (sensor_raw[g]),
      .acc_o  (acc_q[g]),
      .acc_d_o(acc_d[g])
    );
  end

`ifdef PLAUSI_CHECK_EN
  plaus_state_e state_q, state_d;
  logic [2:0]   x_q, x_d;
  logic         fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PS_OK:    if (!is_plausible(acc_q)) state_d = PS_FAULT;
      PS_FAULT: if (fault_clr && is_plausible(acc_q)) state_d = PS_OK;
      default:  state_d = PS_OK;
    endcase
    // Outputs come from next-state values so they are registered yet track acc with no lag.
    x_d     = (state_d == PS_FAULT) ? FAILSAFE_VEC : acc_d;
    fault_d = (state_d == PS_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PS_OK;
      x_q     <= 3'b000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      fault_q <= fault_d;
    end
  end

  assign x     = x_q;
  assign fault = fault_q;
`else
  logic       unused_fault_clr;
  logic [2:0] unused_acc_d;

  assign unused_fault_clr = fault_clr;
  assign unused_acc_d     = acc_d;
  assign x                = acc_q;
  assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_pegel_filter.sv
// Bench for pegel_filter (DEBOUNCE_CYCLES=4): directed literal checks plus
// randomized stimulus against a sample-window reference model, both builds.
module tb_pegel_filter;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sensor_raw = 3'b000;
  logic       fault_clr = 1'b0;
  logic [2:0] x;
  logic       fault;

  int ncmp = 0;
  int nerr = 0;

  pegel_filter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .fault_clr(fault_clr),
    .x(x), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: raw sampled each edge, seen by the debouncer two edges
  // later; a bit flips once its last DC seen samples all differ from it.
  logic [2:0] raw_h[$];
  logic [2:0] seen_h[$];
  logic [2:0] macc;
  logic       mst;
  logic [2:0] mx;
  logic       mf;

  function automatic logic plaus(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [2:0] seen, nacc;
    logic       nst, all_diff;
    if (rst) begin
      raw_h.delete();
      seen_h.delete();
      macc <= 3'b000;
      mst  <= 1'b0;
      mx   <= 3'b000;
      mf   <= 1'b0;
    end else begin
      raw_h.push_back(sensor_raw);
      if (raw_h.size() > 3) void'(raw_h.pop_front());
      seen = (raw_h.size() == 3) ? raw_h[0] : 3'b000;
      seen_h.push_back(seen);
      if (seen_h.size() > DC) void'(seen_h.pop_front());
      nacc = macc;
      if (seen_h.size() == DC) begin
        for (int b = 0; b < 3; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < DC; k++)
            if (seen_h[k][b] == macc[b]) all_diff = 1'b0;
          if (all_diff) nacc[b] = ~macc[b];
        end
      end
`ifdef PLAUSI_CHECK_EN
      nst = mst;
      if (!mst && !plaus(macc)) nst = 1'b1;
      else if (mst && fault_clr && plaus(macc)) nst = 1'b0;
`else
      nst = 1'b0;
`endif
      macc <= nacc;
      mst  <= nst;
      mx   <= nst ? 3'b111 : nacc;
      mf   <= nst;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_x", {1'b0, x}, {1'b0, mx});
      check("model_fault", {3'b0, fault}, {3'b0, mf});
    end
  end

  initial begin
    #3;
    check("reset_x", {1'b0, x}, 4'h0);
    check("reset_fault", {3'b0, fault}, 4'h0);
    tick(2);
    rst = 1'b0;

    // 000 -> 001 held: accepted after exactly DC+2 edges
    sensor_raw = 3'b001;
    tick(DC + 1);
    check("latency_early_x", {1'b0, x}, 4'h0);
    tick(1);
    check("latency_x", {1'b0, x}, 4'h1);
    check("latency_fault", {3'b0, fault}, 4'h0);

    // bit1 glitch shorter than DC: no change
    sensor_raw = 3'b011;
    tick(3);
    sensor_raw = 3'b001;
    tick(8);
    check("glitch_x", {1'b0, x}, 4'h1);

`ifdef PLAUSI_CHECK_EN
    sensor_raw = 3'b010;
    tick(DC + 2);
    check("implaus_acc_x", {1'b0, x}, 4'h2);
    check("implaus_acc_fault", {3'b0, fault}, 4'h0);
    tick(1);
    check("fault_x", {1'b0, x}, 4'h7);
    check("fault_fault", {3'b0, fault}, 4'h1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("clr_ignored", {3'b0, fault}, 4'h1);

    sensor_raw = 3'b011;
    tick(DC + 3);
    check("fault_hold_x", {1'b0, x}, 4'h7);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("recover_x", {1'b0, x}, 4'h3);
    check("recover_fault", {3'b0, fault}, 4'h0);

    // async reset while in FAULT
    sensor_raw = 3'b100;
    tick(DC + 4);
    check("fault2_fault", {3'b0, fault}, 4'h1);
    #1 rst = 1'b1;
    #1;
    check("async_fault_x", {1'b0, x}, 4'h0);
    check("async_fault_fault", {3'b0, fault}, 4'h0);
    sensor_raw = 3'b000;
    tick(2);
    rst = 1'b0;
`else
    // raw 100 from reset state: accepted after DC+2 edges, never a fault
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    sensor_raw = 3'b100;
    tick(DC + 1);
    check("nochk_early_x", {1'b0, x}, 4'h0);
    tick(1);
    check("nochk_x", {1'b0, x}, 4'h4);
    check("nochk_fault", {3'b0, fault}, 4'h0);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("nochk_clr_x", {1'b0, x}, 4'h4);
`endif

    // async reset mid-count discards progress
    sensor_raw = 3'b001;
    tick(DC + 2);
    check("pre_rst_x", {1'b0, x}, 4'h1);
    sensor_raw = 3'b011;
    tick(3);
    #1 rst = 1'b1;
    #1;
    check("async_mid_x", {1'b0, x}, 4'h0);
    check("async_mid_fault", {3'b0, fault}, 4'h0);
    tick(2);
    rst = 1'b0;
    tick(DC + 1);
    check("post_rst_early_x", {1'b0, x}, 4'h0);
    tick(1);
    check("post_rst_x", {1'b0, x}, 4'h3);

    // randomized: held raw values of random length, sporadic fault_clr
    for (int i = 0; i < 300; i++) begin
      int hold;
      sensor_raw = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 2 * DC + 3);
      for (int j = 0; j < hold; j++) begin
        fault_clr = ($urandom_range(0, 4) == 0);
        tick(1);
      end
      if ($urandom_range(0, 60) == 0) begin
        #1 rst = 1'b1;
        #1 check("rand_rst_x", {1'b0, x}, 4'h0);
        tick(1);
        rst = 1'b0;
      end
    end
    fault_clr = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pegel_filter.md
PEGEL_FILTER -- requirements
Module: pegel_filter

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1000, number of consecutive stable synchronized samples before a sensor bit is accepted (legal range 2..65535).
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port sensor_raw  input  3  raw, asynchronous level switches: bit0 low, bit1 mid, bit2 high; 1 = wet.
REQ-005 SHALL provide port fault_clr  input  1  synchronous request to leave the fault state.
REQ-006 SHALL provide port x  output  3  filtered level vector consumed by the downstream pump control FSM.
REQ-007 SHALL provide port fault  output  1  plausibility fault indicator.

Function
REQ-008 SHALL pass each sensor_raw bit through its own two-flop synchronizer before any other logic uses it.
REQ-009 SHALL keep, per bit, an accepted value and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-010 SHALL clear a bit's counter in any cycle where its synchronized sample equals its accepted value.
REQ-011 SHALL increment the counter while the synchronized sample differs, and on the edge where it would reach DEBOUNCE_CYCLES SHALL update the accepted value and clear the counter.
REQ-012 SHALL produce a latency of exactly DEBOUNCE_CYCLES+2 rising edges from a held raw change to the changed accepted bit.
REQ-013 SHALL restart a bit's count from zero on any glitch shorter than DEBOUNCE_CYCLES samples, leaving its accepted value unchanged.
REQ-014 SHALL treat accepted vectors 000, 001, 011 and 111 as plausible and all other vectors as implausible.
REQ-015 SHALL implement a two-state FSM with states OK and FAULT.
REQ-016 SHALL, in OK, transition to FAULT on the edge after the accepted vector becomes implausible.
REQ-017 SHALL, in FAULT, return to OK only on an edge where fault_clr=1 and the accepted vector is plausible.
REQ-018 SHALL ignore fault_clr while the vector is implausible and SHALL ignore fault_clr in OK.
REQ-019 SHALL register outputs: x = accepted vector and fault = 0 in OK; x = 3'b111 (fail-safe, maximum pumping) and fault = 1 in FAULT.

Reset
REQ-020 SHALL, while rst=1, force synchronizers, accepted values and counters to 0, FSM to OK, x = 000 and fault = 0.
REQ-021 SHALL, on rst assertion mid-debounce or in FAULT, discard all progress immediately and resume from the reset state on the first edge after release.

Configuration
REQ-022 SHALL, with macro PLAUSI_CHECK_EN defined, include the plausibility check and FSM as specified in REQ-014 to REQ-019.
REQ-023 SHALL, without PLAUSI_CHECK_EN, omit the FSM entirely, tie fault to 0, ignore fault_clr and drive x = accepted vector at all times.

Structure
REQ-024 SHALL take the FSM state encodings, the fail-safe vector 3'b111 and the plausible-code constants from the shared pumpen package, which the pump control FSM also uses.
REQ-025 SHALL implement synchronizer plus debounce counter as one sub-module entprell_kanal, instantiated three times.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 SHALL cover: sensor_raw 000->001, held -> x=001 exactly 6 edges later, fault=0.
REQ-027 SHALL cover: bit1 pulse of 3 synchronized cycles on 001 -> x remains 001, bit1 counter returns to 0.
REQ-028 SHALL cover: sensor_raw 000->010, held -> x=111 and fault=1 one edge after accepted becomes 010; fault_clr pulsed while raw=010 -> fault stays 1.
REQ-029 SHALL cover: in FAULT, raw changed to 011 and accepted, then fault_clr=1 for one edge -> x=011 and fault=0 on the next edge.
REQ-030 SHALL cover: rst asserted asynchronously mid-count and in FAULT -> x=000 and fault=0 immediately, no clock edge required.
REQ-031 SHALL cover: build without PLAUSI_CHECK_EN, raw 100 held -> x=100 after 6 edges, fault=0.
